// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// regfile_pkg : shared state encoding and default geometry for regfile_mp
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int DW_DEF  = 32;
   localparam int AW_DEF  = 6;
   localparam int NRD_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/regfile_rdport.sv
//------------------------------------------------------------------------------
// regfile_rdport : one registered read port with write-first byte-merge bypass
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   mem_word,
   input  logic            wr_ok,
   input  logic [AW-1:0]   w_addr,
   input  logic [DW-1:0]   w_data,
   input  logic [DW/8-1:0] w_be,
   output logic [DW-1:0]   data,
   output logic            valid
);

   localparam int NB = DW / 8;

   logic          hit;
   logic [DW-1:0] merged;

   assign hit = wr_ok && (w_addr == addr);

   // Bytes being written this edge come from the write bus, the rest from storage.
   always_comb begin
      merged = mem_word;
      for (int k = 0; k < NB; k++) begin
         if (hit && w_be[k]) begin
            merged[k*8 +: 8] = w_data[k*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= en;
         if (en) begin
            data <= merged;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
//------------------------------------------------------------------------------
// regfile_mp : multi-read-port byte-writable register file with init sweep
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_mp
   import regfile_pkg::*;
#(
   parameter int              DW    = DW_DEF,
   parameter int              AW    = AW_DEF,
   parameter int              NRD   = NRD_DEF,
   parameter logic [DW-1:0]   INIT0 = DW'(32'h0002),
   parameter logic [DW-1:0]   INIT1 = DW'(32'h0002)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              w_en,
   input  logic [AW-1:0]     w_addr,
   input  logic [DW-1:0]     w_data,
   input  logic [DW/8-1:0]   w_be,
   input  logic [NRD-1:0]    r_en,
   input  logic [NRD*AW-1:0] r_addr,
   output logic [NRD*DW-1:0] r_data,
   output logic [NRD-1:0]    r_valid,
   output logic              ready
);

   localparam int            DEPTH    = 2 ** AW;
   localparam int            NB       = DW / 8;
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [DW-1:0] mem [DEPTH];

   state_t        state;
   state_t        state_d;
   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_d;
   logic [DW-1:0] init_val;
   logic          sweep_we;
   logic          wr_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
         ptr   <= '0;
      end else begin
         state <= state_d;
         ptr   <= ptr_d;
      end
   end

   // The pointer wraps to 0 on the same edge that enters READY.
   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      case (state)
         ST_INIT: begin
            ptr_d = ptr + 1'b1;
            if (ptr == PTR_LAST) begin
               state_d = ST_READY;
            end
         end
         ST_READY: ;
         default:  state_d = ST_INIT;
      endcase
      if (clr) begin
         state_d = ST_INIT;
         ptr_d   = '0;
      end
   end

   assign ready = (state == ST_READY);

   always_comb begin
      init_val = '0;
      if (ptr == AW'(0)) begin
         init_val = INIT0;
      end else if (ptr == AW'(1)) begin
         init_val = INIT1;
      end
   end

   assign sweep_we = (state == ST_INIT)  && !rst && !clr;
   assign wr_ok    = (state == ST_READY) && w_en && !rst && !clr;

   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[ptr] <= init_val;
      end else if (wr_ok) begin
         for (int k = 0; k < NB; k++) begin
            if (w_be[k]) begin
               mem[w_addr][k*8 +: 8] <= w_data[k*8 +: 8];
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < NRD; g++) begin : g_rdport
         regfile_rdport #(
            .DW (DW),
            .AW (AW)
         ) u_rdport (
            .clk      (clk),
            .rst      (rst),
            .en       (r_en[g] && ready),
            .addr     (r_addr[g*AW +: AW]),
            .mem_word (mem[r_addr[g*AW +: AW]]),
            .wr_ok    (wr_ok),
            .w_addr   (w_addr),
            .w_data   (w_data),
            .w_be     (w_be),
            .data     (r_data[g*DW +: DW]),
            .valid    (r_valid[g])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//------------------------------------------------------------------------------
// tb_regfile_mp : directed self-checking bench for regfile_mp (DW=32 AW=6 NRD=2)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

   localparam int DW  = 32;
   localparam int AW  = 6;
   localparam int NRD = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic              w_en;
   logic [AW-1:0]     w_addr;
   logic [DW-1:0]     w_data;
   logic [DW/8-1:0]   w_be;
   logic [NRD-1:0]    r_en;
   logic [NRD*AW-1:0] r_addr;
   logic [NRD*DW-1:0] r_data;
   logic [NRD-1:0]    r_valid;
   logic              ready;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_mp #(
      .DW  (DW),
      .AW  (AW),
      .NRD (NRD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .w_en    (w_en),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .w_be    (w_be),
      .r_en    (r_en),
      .r_addr  (r_addr),
      .r_data  (r_data),
      .r_valid (r_valid),
      .ready   (ready)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr    = 1'b0;
      w_en   = 1'b0;
      w_addr = '0;
      w_data = '0;
      w_be   = '0;
      r_en   = '0;
      r_addr = '0;
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!ready && cnt < 200) begin
         tick();
         cnt++;
      end
   endtask

   task automatic test_reset();
      int cnt;
      idle();
      rst = 1'b1;
      tick();
      tick();
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready got=%0b exp=0", ready);
      end
      n_tests++;
      if (r_valid !== 2'b00) begin
         n_fail++; $display("FAIL reset_valid got=%b exp=00", r_valid);
      end
      n_tests++;
      if (r_data !== 64'h0) begin
         n_fail++; $display("FAIL reset_data got=%h exp=0", r_data);
      end
      rst = 1'b0;
      wait_ready(cnt);
      n_tests++;
      if (cnt !== 64) begin
         n_fail++; $display("FAIL sweep_len got=%0d exp=64", cnt);
      end
   endtask

   task automatic test_init_values();
      r_en   = 2'b11;
      r_addr = {6'd1, 6'd0};
      tick();
      r_en = 2'b00;
      n_tests++;
      if (r_data !== {32'h2, 32'h2} || r_valid !== 2'b11) begin
         n_fail++; $display("FAIL init_addr0_1 got=%h/%b exp=%h/11", r_data, r_valid, {32'h2, 32'h2});
      end
      r_en   = 2'b01;
      r_addr = {6'd0, 6'd63};
      tick();
      r_en = 2'b00;
      n_tests++;
      if (r_data !== {32'h2, 32'h0} || r_valid !== 2'b01) begin
         n_fail++; $display("FAIL init_addr63_hold got=%h/%b exp=%h/01", r_data, r_valid, {32'h2, 32'h0});
      end
   endtask

   task automatic test_full_write();
      w_en = 1'b1; w_addr = 6'd5; w_data = 32'hDEADBEEF; w_be = 4'hF;
      tick();
      w_en   = 1'b0;
      r_en   = 2'b01;
      r_addr = {6'd0, 6'd5};
      tick();
      r_en = 2'b00;
      n_tests++;
      if (r_data[31:0] !== 32'hDEADBEEF || r_valid !== 2'b01) begin
         n_fail++; $display("FAIL full_write got=%h/%b exp=deadbeef/01", r_data[31:0], r_valid);
      end
      tick();
      n_tests++;
      if (r_valid !== 2'b00 || r_data[31:0] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL valid_one_cycle got=%h/%b exp=deadbeef/00", r_data[31:0], r_valid);
      end
   endtask

   task automatic test_byte_write();
      w_en = 1'b1; w_addr = 6'd5; w_data = 32'h11223344; w_be = 4'b0101;
      tick();
      w_en = 1'b1; w_addr = 6'd5; w_data = 32'hFFFFFFFF; w_be = 4'b0000;
      tick();
      w_en   = 1'b0;
      r_en   = 2'b10;
      r_addr = {6'd5, 6'd0};
      tick();
      r_en = 2'b00;
      n_tests++;
      if (r_data[63:32] !== 32'hDE22BE44 || r_valid !== 2'b10) begin
         n_fail++; $display("FAIL byte_write got=%h/%b exp=de22be44/10", r_data[63:32], r_valid);
      end
   endtask

   task automatic test_bypass();
      w_en = 1'b1; w_addr = 6'd7; w_data = 32'hA5A5A5A5; w_be = 4'hF;
      r_en = 2'b11; r_addr = {6'd7, 6'd7};
      tick();
      idle();
      n_tests++;
      if (r_data !== {32'hA5A5A5A5, 32'hA5A5A5A5} || r_valid !== 2'b11) begin
         n_fail++; $display("FAIL bypass_full got=%h/%b exp=a5a5a5a5a5a5a5a5/11", r_data, r_valid);
      end
      w_en = 1'b1; w_addr = 6'd5; w_data = 32'h77000000; w_be = 4'b1000;
      r_en = 2'b11; r_addr = {6'd5, 6'd5};
      tick();
      idle();
      n_tests++;
      if (r_data !== {32'h7722BE44, 32'h7722BE44}) begin
         n_fail++; $display("FAIL bypass_partial got=%h exp=7722be447722be44", r_data);
      end
   endtask

   task automatic test_clr_write();
      int cnt;
      clr = 1'b1;
      w_en = 1'b1; w_addr = 6'd9; w_data = 32'h1234; w_be = 4'hF;
      tick();
      idle();
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL clr_ready_fall got=%0b exp=0", ready);
      end
      wait_ready(cnt);
      n_tests++;
      if (cnt !== 64) begin
         n_fail++; $display("FAIL clr_sweep_len got=%0d exp=64", cnt);
      end
      r_en   = 2'b11;
      r_addr = {6'd0, 6'd9};
      tick();
      r_en = 2'b00;
      n_tests++;
      if (r_data !== {32'h2, 32'h0} || r_valid !== 2'b11) begin
         n_fail++; $display("FAIL clr_contents got=%h/%b exp=%h/11", r_data, r_valid, {32'h2, 32'h0});
      end
   endtask

   task automatic test_write_not_ready();
      int cnt;
      int seen_valid;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      seen_valid = 0;
      w_en = 1'b1; w_addr = 6'd3; w_data = 32'hFFFF; w_be = 4'hF;
      r_en = 2'b11; r_addr = {6'd3, 6'd3};
      for (int i = 0; i < 40; i++) begin
         tick();
         if (r_valid !== 2'b00) seen_valid++;
      end
      n_tests++;
      if (seen_valid !== 0 || ready !== 1'b0) begin
         n_fail++; $display("FAIL not_ready_valid got=%0d/%0b exp=0/0", seen_valid, ready);
      end
      w_en = 1'b0;
      r_en = 2'b00;
      wait_ready(cnt);
      n_tests++;
      if (cnt !== 24) begin
         n_fail++; $display("FAIL rst_restart_len got=%0d exp=24", cnt);
      end
      r_en   = 2'b01;
      r_addr = {6'd0, 6'd3};
      tick();
      r_en = 2'b00;
      n_tests++;
      if (r_data[31:0] !== 32'h0 || r_valid !== 2'b01) begin
         n_fail++; $display("FAIL not_ready_write got=%h/%b exp=0/01", r_data[31:0], r_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_init_values();
      test_full_write();
      test_byte_write();
      test_bypass();
      test_clr_write();
      test_write_not_ready();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
